// File: rtl/bp_me_wb_arbiter.sv
// Round-robin N-to-1 Wishbone B4 master arbiter for the BedRock-to-WB converters.
// The grant is held for a whole cyc; a strobe left unanswered too long is aborted with err.
module bp_me_wb_arbiter #(
    parameter int num_master_p = 2,
    parameter int data_width_p = 64,
    parameter int adr_width_p  = 37,
    parameter int timeout_p    = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [num_master_p-1:0][adr_width_p-1:0]      m_adr_i,
    input  logic [num_master_p-1:0][data_width_p-1:0]     m_dat_i,
    input  logic [num_master_p-1:0][data_width_p/8-1:0]   m_sel_i,
    input  logic [num_master_p-1:0]                       m_cyc_i,
    input  logic [num_master_p-1:0]                       m_stb_i,
    input  logic [num_master_p-1:0]                       m_we_i,
    input  logic [num_master_p-1:0][2:0]                  m_cti_i,
    input  logic [num_master_p-1:0][1:0]                  m_bte_i,
    output logic [num_master_p-1:0]                       m_ack_o,
    output logic [num_master_p-1:0]                       m_err_o,
    output logic [num_master_p-1:0][data_width_p-1:0]     m_dat_o,
    output logic [adr_width_p-1:0]                        adr_o,
    output logic [data_width_p-1:0]                       dat_o,
    output logic [data_width_p/8-1:0]                     sel_o,
    output logic                                          cyc_o,
    output logic                                          stb_o,
    output logic                                          we_o,
    output logic [2:0]                                    cti_o,
    output logic [1:0]                                    bte_o,
    input  logic                                          ack_i,
    input  logic                                          err_i,
    input  logic [data_width_p-1:0]                       dat_i
);

    localparam int lg_master_lp = (num_master_p > 1) ? $clog2(num_master_p) : 1;
    localparam int tmo_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;

    typedef logic [lg_master_lp-1:0] idx_t;
    typedef logic [tmo_width_lp-1:0] tmo_t;
    typedef enum logic [1:0] {e_idle, e_busy, e_abort} state_e;

    localparam idx_t last_reset_lp = idx_t'(num_master_p - 1);
    localparam tmo_t tmo_last_lp   = tmo_t'((timeout_p > 0) ? (timeout_p - 1) : 0);

    state_e state_r, state_n;
    idx_t   grant_r, grant_n;
    idx_t   last_r, last_n;
    tmo_t   tmo_cnt_r, tmo_n;
    logic   stall;

    // Lowest offset after the previous owner wins; scanning backwards lets it overwrite the rest.
    function automatic idx_t rr_pick(input idx_t last, input logic [num_master_p-1:0] req);
        int idx;
        rr_pick = last;
        for (int i = num_master_p; i >= 1; i--) begin
            idx = (int'(last) + i) % num_master_p;
            if (req[idx]) rr_pick = idx_t'(idx);
        end
    endfunction

    always_comb begin
        for (int i = 0; i < num_master_p; i++) m_dat_o[i] = dat_i;
    end

    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        last_n  = last_r;
        tmo_n   = tmo_cnt_r;
        adr_o   = '0;
        dat_o   = '0;
        sel_o   = '0;
        cyc_o   = 1'b0;
        stb_o   = 1'b0;
        we_o    = 1'b0;
        cti_o   = '0;
        bte_o   = '0;
        m_ack_o = '0;
        m_err_o = '0;
        stall   = m_stb_i[grant_r] & ~ack_i & ~err_i;

        case (state_r)
            e_idle: begin
                tmo_n = '0;
                if (|m_cyc_i) begin
                    grant_n = rr_pick(last_r, m_cyc_i);
                    state_n = e_busy;
                end
            end
            e_busy: begin
                adr_o = m_adr_i[grant_r];
                dat_o = m_dat_i[grant_r];
                sel_o = m_sel_i[grant_r];
                we_o  = m_we_i[grant_r];
                cti_o = m_cti_i[grant_r];
                bte_o = m_bte_i[grant_r];
                cyc_o = m_cyc_i[grant_r];
                stb_o = m_stb_i[grant_r];
                m_ack_o[grant_r] = ack_i;
                m_err_o[grant_r] = err_i;
                if (!m_cyc_i[grant_r]) begin
                    last_n  = grant_r;
                    state_n = e_idle;
                    tmo_n   = '0;
                end else if ((timeout_p > 0) && stall && (tmo_cnt_r == tmo_last_lp)) begin
                    // Abort: the owner sees err now and the slave sees the cycle vanish.
                    m_err_o[grant_r] = 1'b1;
                    cyc_o   = 1'b0;
                    stb_o   = 1'b0;
                    state_n = e_abort;
                    tmo_n   = '0;
                end else if ((timeout_p > 0) && stall) begin
                    tmo_n = (tmo_cnt_r == '1) ? tmo_cnt_r : tmo_cnt_r + 1'b1;
                end else begin
                    tmo_n = '0;
                end
            end
            e_abort: begin
                if (!m_cyc_i[grant_r]) begin
                    last_n  = grant_r;
                    state_n = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_idle;
            grant_r   <= '0;
            last_r    <= last_reset_lp;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_n;
            grant_r   <= grant_n;
            last_r    <= last_n;
            tmo_cnt_r <= tmo_n;
        end
    end

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Bench for bp_me_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an owner/abort reference model.
module tb_bp_me_wb_arbiter;

    localparam int N   = 3;
    localparam int DW  = 64;
    localparam int AW  = 37;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic clk;
    logic rst;
    logic [N-1:0][AW-1:0] m_adr;
    logic [N-1:0][DW-1:0] m_dat;
    logic [N-1:0][SW-1:0] m_sel;
    logic [N-1:0]         m_cyc;
    logic [N-1:0]         m_stb;
    logic [N-1:0]         m_we;
    logic [N-1:0][2:0]    m_cti;
    logic [N-1:0][1:0]    m_bte;
    logic [N-1:0]         m_ack;
    logic [N-1:0]         m_err;
    logic [N-1:0][DW-1:0] m_rdat;
    logic [AW-1:0]        adr_o;
    logic [DW-1:0]        dat_o;
    logic [SW-1:0]        sel_o;
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [2:0]           cti_o;
    logic [1:0]           bte_o;
    logic                 ack_i;
    logic                 err_i;
    logic [DW-1:0]        dat_i;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (-1 = nobody), whether the transfer was aborted,
    // how many consecutive unanswered strobes, and who owned the bus last.
    int mo_owner = -1;
    bit mo_abort = 1'b0;
    int mo_stall = 0;
    int mo_last  = N - 1;
    bit model_ok = 1'b0;

    int            rr_order [3] = '{2, 0, 1};
    logic [AW-1:0] rr_adr   [3] = '{37'h300, 37'h100, 37'h200};

    bp_me_wb_arbiter #(
        .num_master_p(N),
        .data_width_p(DW),
        .adr_width_p (AW),
        .timeout_p   (TMO)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .m_adr_i(m_adr),
        .m_dat_i(m_dat),
        .m_sel_i(m_sel),
        .m_cyc_i(m_cyc),
        .m_stb_i(m_stb),
        .m_we_i (m_we),
        .m_cti_i(m_cti),
        .m_bte_i(m_bte),
        .m_ack_o(m_ack),
        .m_err_o(m_err),
        .m_dat_o(m_rdat),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .sel_o  (sel_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .cti_o  (cti_o),
        .bte_o  (bte_o),
        .ack_i  (ack_i),
        .err_i  (err_i),
        .dat_i  (dat_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_fire();
        return (mo_owner >= 0) && !mo_abort && m_cyc[mo_owner] && m_stb[mo_owner]
               && !ack_i && !err_i && (mo_stall == TMO - 1);
    endfunction

    task automatic compare_cycle();
        logic [N-1:0]  e_ack;
        logic [N-1:0]  e_err;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic [2:0]    e_cti;
        logic [1:0]    e_bte;
        logic          e_cyc;
        logic          e_stb;
        logic          e_we;
        bit            fire;
        fire  = model_fire();
        e_ack = '0;
        e_err = '0;
        e_adr = '0;
        e_dat = '0;
        e_sel = '0;
        e_cti = '0;
        e_bte = '0;
        e_cyc = 1'b0;
        e_stb = 1'b0;
        e_we  = 1'b0;
        if (mo_owner >= 0 && !mo_abort) begin
            e_adr = m_adr[mo_owner];
            e_dat = m_dat[mo_owner];
            e_sel = m_sel[mo_owner];
            e_cti = m_cti[mo_owner];
            e_bte = m_bte[mo_owner];
            e_we  = m_we[mo_owner];
            e_cyc = m_cyc[mo_owner] && !fire;
            e_stb = m_stb[mo_owner] && !fire;
            e_ack[mo_owner] = ack_i;
            e_err[mo_owner] = err_i || fire;
        end
        chk("model_cyc_o", cyc_o, e_cyc);
        chk("model_stb_o", stb_o, e_stb);
        chk("model_we_o", we_o, e_we);
        chk("model_adr_o", adr_o, e_adr);
        chk("model_dat_o", dat_o, e_dat);
        chk("model_sel_o", sel_o, e_sel);
        chk("model_cti_o", cti_o, e_cti);
        chk("model_bte_o", bte_o, e_bte);
        chk("model_m_ack_o", m_ack, e_ack);
        chk("model_m_err_o", m_err, e_err);
        for (int i = 0; i < N; i++) chk("model_m_dat_o", m_rdat[i], dat_i);
    endtask

    always @(negedge clk) begin
        if (model_ok) compare_cycle();
    end

    always @(posedge clk) begin
        if (rst) begin
            mo_owner <= -1;
            mo_abort <= 1'b0;
            mo_stall <= 0;
            mo_last  <= N - 1;
            model_ok <= 1'b1;
        end else if (mo_owner < 0) begin
            if (m_cyc != '0) begin
                mo_owner <= rr_pick(mo_last, m_cyc);
                mo_stall <= 0;
                mo_abort <= 1'b0;
            end
        end else if (!m_cyc[mo_owner]) begin
            mo_last  <= mo_owner;
            mo_owner <= -1;
            mo_abort <= 1'b0;
            mo_stall <= 0;
        end else if (model_fire()) begin
            mo_abort <= 1'b1;
            mo_stall <= 0;
        end else if (!mo_abort) begin
            mo_stall <= (m_stb[mo_owner] && !ack_i && !err_i) ? mo_stall + 1 : 0;
        end
    end

    task automatic idle_inputs();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        m_adr = '0;
        m_dat = '0;
        m_sel = '0;
        m_cti = '0;
        m_bte = '0;
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int toggle_div, input int ack_div);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, toggle_div - 1) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                m_adr[i] = AW'({$urandom(), $urandom()});
                m_dat[i] = {$urandom(), $urandom()};
                m_sel[i] = SW'($urandom());
                m_we[i]  = ($urandom_range(0, 1) == 1);
                m_cti[i] = 3'($urandom());
                m_bte[i] = 2'($urandom());
            end
            ack_i = ($urandom_range(0, ack_div - 1) == 0);
            err_i = ($urandom_range(0, 4 * ack_div - 1) == 0);
            dat_i = {$urandom(), $urandom()};
            rst   = ($urandom_range(0, 299) == 0);
            next();
        end
        rst = 1'b0;
        idle_inputs();
        next();
        next();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        next();
        next();
        settle();
        chk("reset_cyc_o", cyc_o, 1'b0);
        chk("reset_stb_o", stb_o, 1'b0);
        chk("reset_adr_o", adr_o, '0);
        chk("reset_m_ack_o", m_ack, '0);
        chk("reset_m_err_o", m_err, '0);
        chk("model_rr_after_reset", 128'(rr_pick(N - 1, 3'b011)), 128'd0);
        chk("model_rr_rotate", 128'(rr_pick(0, 3'b011)), 128'd1);
        chk("model_rr_wrap", 128'(rr_pick(1, 3'b101)), 128'd2);
        rst = 1'b0;
        next();

        // Single master read, slave acks on the third bus cycle.
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_adr[1] = 37'h40;
        m_sel[1] = 8'hFF;
        settle();
        chk("single_idle_cyc", cyc_o, 1'b0);
        next();
        settle();
        chk("single_cyc_rise", cyc_o, 1'b1);
        chk("single_adr", adr_o, 37'h40);
        next();
        settle();
        chk("single_no_ack_yet", m_ack[1], 1'b0);
        next();
        ack_i = 1'b1;
        dat_i = 64'hDEAD_BEEF_0123_4567;
        settle();
        chk("single_ack1", m_ack[1], 1'b1);
        chk("single_ack0", m_ack[0], 1'b0);
        chk("single_rdata", m_rdat[1], 64'hDEAD_BEEF_0123_4567);
        next();
        idle_inputs();
        settle();
        chk("single_drop_cyc", cyc_o, 1'b0);
        next();

        // Contention straight after reset, then a three-way rotation.
        do_reset();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_adr[0] = 37'h100;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_adr[1] = 37'h200;
        m_adr[2] = 37'h300;
        next();
        ack_i = 1'b1;
        settle();
        chk("cont_first_adr", adr_o, 37'h100);
        chk("cont_ack0", m_ack[0], 1'b1);
        chk("cont_ack1_blocked", m_ack[1], 1'b0);
        next();
        ack_i = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        settle();
        chk("cont_release_cyc", cyc_o, 1'b0);
        next();
        settle();
        chk("cont_turnaround_cyc", cyc_o, 1'b0);
        next();
        ack_i = 1'b1;
        settle();
        chk("cont_second_cyc", cyc_o, 1'b1);
        chk("cont_second_adr", adr_o, 37'h200);
        next();
        ack_i = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        next();
        m_cyc = 3'b111;
        m_stb = 3'b111;
        for (int k = 0; k < 3; k++) begin
            next();
            ack_i = 1'b1;
            settle();
            chk("rr_owner_adr", adr_o, rr_adr[k]);
            chk("rr_owner_ack", m_ack, 3'b001 << rr_order[k]);
            next();
            ack_i = 1'b0;
            m_cyc[rr_order[k]] = 1'b0;
            m_stb[rr_order[k]] = 1'b0;
            next();
        end

        // Burst lock: master 0 holds cyc for 8 beats while master 1 waits.
        do_reset();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_adr[1] = 37'h2000;
        next();
        for (int b = 0; b < 8; b++) begin
            m_cti[0] = (b == 7) ? 3'b111 : 3'b010;
            m_adr[0] = 37'h1000 + AW'(b);
            ack_i = 1'b1;
            settle();
            chk("burst_cyc", cyc_o, 1'b1);
            chk("burst_cti", cti_o, (b == 7) ? 3'b111 : 3'b010);
            chk("burst_ack0", m_ack[0], 1'b1);
            chk("burst_ack1_blocked", m_ack[1], 1'b0);
            next();
        end
        ack_i = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        m_cti[0] = 3'b000;
        settle();
        chk("burst_end_cyc", cyc_o, 1'b0);
        next();
        next();
        settle();
        chk("burst_next_owner_adr", adr_o, 37'h2000);
        next();
        idle_inputs();
        next();

        // Timeout: slave never answers master 0.
        do_reset();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_adr[0] = 37'h55;
        next();
        for (int s = 1; s <= TMO; s++) begin
            settle();
            if (s < TMO) begin
                chk("tmo_wait_err", m_err[0], 1'b0);
                chk("tmo_wait_cyc", cyc_o, 1'b1);
            end else begin
                chk("tmo_err_pulse", m_err[0], 1'b1);
                chk("tmo_cyc_cut", cyc_o, 1'b0);
                chk("tmo_stb_cut", stb_o, 1'b0);
            end
            next();
        end
        ack_i = 1'b1;
        settle();
        chk("tmo_late_ack_dropped", m_ack[0], 1'b0);
        chk("tmo_abort_cyc", cyc_o, 1'b0);
        chk("tmo_abort_err", m_err[0], 1'b0);
        next();
        idle_inputs();
        next();

        // Error forwarding on a write from master 1, then reset in the middle of its burst.
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_we[1]  = 1'b1;
        m_adr[1] = 37'h77;
        m_dat[1] = 64'h0000_0000_CAFE_F00D;
        next();
        err_i = 1'b1;
        settle();
        chk("errfwd_err1", m_err[1], 1'b1);
        chk("errfwd_err0", m_err[0], 1'b0);
        chk("errfwd_we", we_o, 1'b1);
        chk("errfwd_dat", dat_o, 64'h0000_0000_CAFE_F00D);
        next();
        err_i = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_adr[0] = 37'h88;
        ack_i = 1'b1;
        settle();
        chk("errfwd_still_busy", cyc_o, 1'b1);
        chk("errfwd_owner_kept", adr_o, 37'h77);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        chk("rst_cyc_drop", cyc_o, 1'b0);
        chk("rst_ack_lost", m_ack, 3'b000);
        next();
        ack_i = 1'b0;
        settle();
        chk("rst_prio_cyc", cyc_o, 1'b1);
        chk("rst_prio_adr", adr_o, 37'h88);
        next();
        idle_inputs();
        next();
        next();

        // Randomized traffic: lively bus, then a slow slave with long-held cycles.
        random_phase(4000, 4, 3);
        random_phase(4000, 40, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
